// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: accepts a word and bit count over valid/ready and
// shifts the selected bits out MSB-first, one per clock, followed by a fixed idle gap.
module serial_bit_tx #(
  parameter int W   = 8,
  parameter int CW  = 4,
  parameter int GAP = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  in_data_i,
  input  logic [CW-1:0] in_len_i,
  output logic          x_o,
  output logic          x_valid_o,
  output logic          done_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP_S = 2'd2
  } state_e;

  localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] W_C      = CW'(W);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);

  state_e        state_q;
  logic [W-1:0]  sreg_q;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] gap_q;
  logic          in_ready_q;
  logic          x_q;
  logic          x_valid_q;
  logic          done_q;
  logic          busy_q;

  logic [CW-1:0] eff_len_d;
  logic [W-1:0]  aligned_d;

  // Effective length (0 or oversize means a full word) and left-aligned word.
  always_comb begin
    eff_len_d = W_C;
    if ((in_len_i == {CW{1'b0}}) || (in_len_i > W_C)) begin
      eff_len_d = W_C;
    end else begin
      eff_len_d = in_len_i;
    end
    aligned_d = in_data_i << (W_C - eff_len_d);
  end

  // Transmit FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sreg_q     <= {W{1'b0}};
      cnt_q      <= {CW{1'b0}};
      gap_q      <= {GW{1'b0}};
      in_ready_q <= 1'b0;
      x_q        <= 1'b0;
      x_valid_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_ready_q && in_valid_i) begin
            state_q    <= SHIFT;
            sreg_q     <= aligned_d;
            cnt_q      <= eff_len_d;
            x_q        <= aligned_d[W-1];
            x_valid_q  <= 1'b1;
            done_q     <= (eff_len_d == CW'(1));
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
            x_q        <= 1'b0;
            x_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        SHIFT: begin
          sreg_q <= sreg_q << 1;
          cnt_q  <= cnt_q - CW'(1);
          // cnt_q counts the bit currently on x, so 1 means it is the last one.
          if (cnt_q <= CW'(1)) begin
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
            if (GAP > 0) begin
              state_q    <= GAP_S;
              gap_q      <= GAP_LOAD;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b1;
            end
          end else begin
            x_q        <= sreg_q[W-2];
            x_valid_q  <= 1'b1;
            done_q     <= (cnt_q == CW'(2));
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        GAP_S: begin
          x_q       <= 1'b0;
          x_valid_q <= 1'b0;
          done_q    <= 1'b0;
          if (gap_q == {GW{1'b0}}) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            gap_q      <= gap_q - GW'(1);
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          x_q        <= 1'b0;
          x_valid_q  <= 1'b0;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign x_o        = x_q;
  assign x_valid_o  = x_valid_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed self-checking bench for serial_bit_tx (W=8, CW=4, GAP=1).
module tb_serial_bit_tx;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_len;
  logic       x;
  logic       x_valid;
  logic       done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  serial_bit_tx #(.W(8), .CW(4), .GAP(1)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_len_i   (in_len),
    .x_o        (x),
    .x_valid_o  (x_valid),
    .done_o     (done),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ex, input logic exv,
                            input logic ed, input logic eb, input logic er);
    check_eq({tag, " x"}, 32'(x), 32'(ex));
    check_eq({tag, " x_valid"}, 32'(x_valid), 32'(exv));
    check_eq({tag, " done"}, 32'(done), 32'(ed));
    check_eq({tag, " busy"}, 32'(busy), 32'(eb));
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'(er));
  endtask

  // Offers a word, waits (bounded) for its first bit, then checks every bit,
  // the single gap cycle and the return to IDLE.
  task automatic send_word(input string tag, input logic [7:0] data, input logic [3:0] len,
                           input int nbits, input logic [7:0] bits);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_len   = len;
    do begin
      step();
      waited++;
    end while (!x_valid && waited < 20);
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_len   = 4'd0;
    check_eq({tag, " accept"}, 32'(x_valid), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      check_outs($sformatf("%s bit%0d", tag, i), bits[nbits-1-i], 1'b1,
                 (i == nbits - 1), 1'b1, 1'b0);
      step();
    end
    check_outs({tag, " gap"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_len   = 4'd0;

    // Reset state and one-edge in_ready rise after release.
    #12;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ready before edge", 32'(in_ready), 32'd0);
    step();
    check_eq("ready after edge", 32'(in_ready), 32'd1);

    send_word("full", 8'b0100_1101, 4'd8, 8, 8'b0100_1101);
    send_word("short", 8'hF5, 4'd3, 3, 8'b0000_0101);
    send_word("len0", 8'h96, 4'd0, 8, 8'h96);
    send_word("len12", 8'h3C, 4'd12, 8, 8'h3C);
    send_word("len1a", 8'hFF, 4'd1, 1, 8'h01);
    send_word("len1b", 8'hFE, 4'd1, 1, 8'h00);

    // Back-to-back with in_valid held: A=1011 then B=0110, both len 4.
    in_valid = 1'b1;
    in_data  = 8'h0B;
    in_len   = 4'd4;
    begin
      int waited = 0;
      do begin
        step();
        waited++;
      end while (!x_valid && waited < 20);
    end
    in_data = 8'h06;
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("b2bA bit%0d", i), ((4'b1011 >> (3 - i)) & 4'b0001) != 4'd0,
                 1'b1, (i == 3), 1'b1, 1'b0);
      step();
    end
    check_outs("b2b gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("b2b idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("b2bB bit%0d", i), ((4'b0110 >> (3 - i)) & 4'b0001) != 4'd0,
                 1'b1, (i == 3), 1'b1, 1'b0);
      step();
    end
    check_outs("b2bB gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("b2bB idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort during bit 4 of an 8-bit all-ones word.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_len   = 4'd8;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_outs($sformatf("abort pre bit%0d", i), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("abort async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_outs("abort held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_outs("abort release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word("after abort", 8'hA5, 4'd8, 8, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
